// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared types: in-flight tag encoding, bus width, grant bundle.
// Optional round-robin contest resolution is enabled by ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INFL_I = 2'd1,
    INFL_D = 2'd2
  } infl_t;

  typedef struct packed {
    logic i;
    logic d;
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle: fetch port, data port, stall and memory port.
// The arbiter takes the slave view; the CPU/memory side takes master.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic            i_ce;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_data;
  logic            i_ack;
  logic            d_ce;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_ack;
  logic            stall;
  logic            m_ce;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [XLEN-1:0] m_rdata;

  modport slave (
    input  i_ce, i_addr,
    input  d_ce, d_we, d_addr, d_wdata,
    input  m_rdata,
    output i_data, i_ack,
    output d_rdata, d_ack,
    output stall,
    output m_ce, m_we, m_addr, m_wdata
  );

  modport master (
    output i_ce, i_addr,
    output d_ce, d_we, d_addr, d_wdata,
    output m_rdata,
    input  i_data, i_ack,
    input  d_rdata, d_ack,
    input  stall,
    input  m_ce, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: one-hot grant between fetch and data requests.
// prio_d_i selects the winner only when both requests are eligible.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic fe_req_i,
  input  logic da_req_i,
  input  logic prio_d_i,
  output gnt_t gnt_o
);

  always_comb begin
    gnt_o = '0;
    unique case (1'b1)
      (fe_req_i & da_req_i): begin
        gnt_o.d = prio_d_i;
        gnt_o.i = ~prio_d_i;
      end
      (da_req_i & ~fe_req_i): gnt_o.d = 1'b1;
      (fe_req_i & ~da_req_i): gnt_o.i = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for a single-port synchronous memory.
// ARB_ROUND_ROBIN_EN: contested grants alternate; otherwise data wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  infl_t           tag_q, tag_d;
  logic [XLEN-1:0] idata_q, drdata_q;
  logic            i_ack, d_ack;
  logic            i_elig, d_elig;
  logic            prio_d;
  gnt_t            gnt;

  assign i_ack  = (tag_q == INFL_I) & ~rst;
  assign d_ack  = (tag_q == INFL_D) & ~rst;

  // The requester being acked cannot be re-granted in that cycle.
  assign i_elig = bus.i_ce & ~rst & (tag_q != INFL_I);
  assign d_elig = bus.d_ce & ~rst & (tag_q != INFL_D);

  arb_pick u_pick (
    .fe_req_i (i_elig),
    .da_req_i (d_elig),
    .prio_d_i (prio_d),
    .gnt_o    (gnt)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  assign prio_d = ptr_q;

  // Favour the loser of the last contest; uncontested grants leave it.
  always_comb begin
    ptr_d = ptr_q;
    if (i_elig & d_elig) ptr_d = gnt.i;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
`else
  assign prio_d = 1'b1;
`endif

  always_comb begin
    tag_d = IDLE;
    unique case (1'b1)
      gnt.i:   tag_d = INFL_I;
      gnt.d:   tag_d = INFL_D;
      default: tag_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= IDLE;
      idata_q  <= '0;
      drdata_q <= '0;
    end else begin
      tag_q <= tag_d;
      if (i_ack) idata_q  <= bus.m_rdata;
      if (d_ack) drdata_q <= bus.m_rdata;
    end
  end

  assign bus.m_ce    = gnt.i | gnt.d;
  assign bus.m_we    = gnt.d & bus.d_we;
  assign bus.m_addr  = gnt.d ? bus.d_addr :
                       (gnt.i ? bus.i_addr : '0);
  assign bus.m_wdata = gnt.d ? bus.d_wdata : '0;

  assign bus.i_ack   = i_ack;
  assign bus.d_ack   = d_ack;
  assign bus.i_data  = i_ack ? bus.m_rdata : idata_q;
  assign bus.d_rdata = d_ack ? bus.m_rdata : drdata_q;

  assign bus.stall = (bus.i_ce & ~gnt.i & ~i_ack) |
                     (bus.d_ce & ~gnt.d & ~d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int W_NONE = 0;
  localparam int W_I    = 1;
  localparam int W_D    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_init(input int idx);
    return 32'h2001000A ^ ((idx - 1) * 32'h9E3779B9);
  endfunction

  // Synchronous single-port memory; unwritten words read mem_init().
  logic [31:0] ram  [256];
  bit          ram_v[256];
  always @(posedge clk) begin
    if (rst) begin
      bus.m_rdata <= '0;
    end else if (bus.m_ce) begin
      if (bus.m_we) begin
        ram[bus.m_addr[9:2]]   <= bus.m_wdata;
        ram_v[bus.m_addr[9:2]] <= 1'b1;
      end else begin
        bus.m_rdata <= ram_v[bus.m_addr[9:2]] ?
          ram[bus.m_addr[9:2]] : mem_init(int'(bus.m_addr[9:2]));
      end
    end
  end

  // Reference model state
  logic [31:0] refmem[256];
  int          last     = W_NONE;
  int          last_win = W_NONE;
  bit          fav_d    = 1'b1;
  bit          m_ai, m_ad;
  logic [31:0] pend_val   = '0;
  logic [31:0] exp_idata  = '0;
  logic [31:0] exp_drdata = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ei, ed, wd, st;
    int w;
    if (rst) begin
      m_ai = 0;
      m_ad = 0;
      check("rst_m_ce", 32'(bus.m_ce), 0);
      check("rst_m_we", 32'(bus.m_we), 0);
      check("rst_i_ack", 32'(bus.i_ack), 0);
      check("rst_d_ack", 32'(bus.d_ack), 0);
      last = W_NONE;
      last_win = W_NONE;
      fav_d = 1'b1;
      exp_idata = '0;
      exp_drdata = '0;
      pend_val = '0;
      return;
    end
    m_ai = (last == W_I);
    m_ad = (last == W_D);
    ei = bus.i_ce && !m_ai;
    ed = bus.d_ce && !m_ad;
    if (ei && ed) begin
`ifdef ARB_ROUND_ROBIN_EN
      wd = fav_d;
      fav_d = !wd;
`else
      wd = 1'b1;
`endif
      w = wd ? W_D : W_I;
    end else begin
      w = ed ? W_D : (ei ? W_I : W_NONE);
    end
    if (m_ai) exp_idata  = pend_val;
    if (m_ad) exp_drdata = pend_val;
    st = (bus.i_ce && w != W_I && !m_ai) ||
         (bus.d_ce && w != W_D && !m_ad);
    check("i_ack", 32'(bus.i_ack), 32'(m_ai));
    check("d_ack", 32'(bus.d_ack), 32'(m_ad));
    check("i_data", bus.i_data, exp_idata);
    check("d_rdata", bus.d_rdata, exp_drdata);
    check("stall", 32'(bus.stall), 32'(st));
    check("m_ce", 32'(bus.m_ce), 32'(w != W_NONE));
    check("m_we", 32'(bus.m_we),
          32'(w == W_D && bus.d_we));
    if (w == W_I) check("m_addr_i", bus.m_addr, bus.i_addr);
    if (w == W_D) check("m_addr_d", bus.m_addr, bus.d_addr);
    if (w == W_D && bus.d_we) begin
      check("m_wdata", bus.m_wdata, bus.d_wdata);
      refmem[bus.d_addr[9:2]] = bus.d_wdata;
    end else if (w != W_NONE) begin
      pend_val = refmem[(w == W_D) ? bus.d_addr[9:2]
                                   : bus.i_addr[9:2]];
    end
    last = w;
    last_win = w;
  endtask

  task automatic drive(input bit r,
                       input bit ic, input logic [31:0] ia,
                       input bit dc, input bit dw,
                       input logic [31:0] da,
                       input logic [31:0] dwd);
    @(posedge clk);
    #1;
    rst = r;
    bus.i_ce = ic;
    bus.i_addr = ia;
    bus.d_ce = dc;
    bus.d_we = dw;
    bus.d_addr = da;
    bus.d_wdata = dwd;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input bit r);
    drive(r, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  logic [31:0] ia, da, dwd;
  bit          i_act, d_act, dw, r;

  initial begin
    for (int k = 0; k < 256; k++) refmem[k] = mem_init(k);
    bus.i_ce = 0; bus.i_addr = 0;
    bus.d_ce = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;

    idle(1); idle(1); idle(0);
    check("rst_idata", bus.i_data, 32'h0);
    check("rst_drdata", bus.d_rdata, 32'h0);

    // Fetch only
    drive(0, 1, 32'h4, 0, 0, 32'h0, 32'h0);
    check("f_c0_mce", 32'(bus.m_ce), 1);
    check("f_c0_stall", 32'(bus.stall), 0);
    drive(0, 1, 32'h4, 0, 0, 32'h0, 32'h0);
    check("f_c1_ack", 32'(bus.i_ack), 1);
    check("f_c1_data", bus.i_data, 32'h2001000A);
    check("f_c1_stall", 32'(bus.stall), 0);
    idle(0);

    // Write then read back
    drive(0, 0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF);
    check("w_mwe", 32'(bus.m_we), 1);
    check("w_mwdata", bus.m_wdata, 32'hDEADBEEF);
    drive(0, 0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF);
    check("w_dack", 32'(bus.d_ack), 1);
    drive(0, 0, 32'h0, 1, 0, 32'h20, 32'h0);
    drive(0, 0, 32'h0, 1, 0, 32'h20, 32'h0);
    check("rb_dack", 32'(bus.d_ack), 1);
    check("rb_data", bus.d_rdata, 32'hDEADBEEF);
    idle(0);

    // Contest from reset: data first, fetch while data acks
    idle(1); idle(0);
    drive(0, 1, 32'h8, 1, 0, 32'h10, 32'h0);
    check("c_c0_addr", bus.m_addr, 32'h10);
    check("c_c0_stall", 32'(bus.stall), 1);
    drive(0, 1, 32'h8, 1, 0, 32'h10, 32'h0);
    check("c_c1_dack", 32'(bus.d_ack), 1);
    check("c_c1_addr", bus.m_addr, 32'h8);
    drive(0, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    check("c_c2_iack", 32'(bus.i_ack), 1);
    idle(0);

    // Sustained contest: D, I, D, I, D, I
    idle(1); idle(0);
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 32'h80, 1, 0, 32'h40, 32'h0);
      check("alt_addr", bus.m_addr,
            (k % 2 == 0) ? 32'h40 : 32'h80);
    end
    idle(0); idle(0);

    // Reset right after a fetch grant
    drive(0, 1, 32'hC, 0, 0, 32'h0, 32'h0);
    check("mr_grant", 32'(bus.m_ce), 1);
    drive(1, 1, 32'hC, 0, 0, 32'h0, 32'h0);
    check("mr_ack0", 32'(bus.i_ack), 0);
    idle(0);
    check("mr_ack1", 32'(bus.i_ack), 0);
    check("mr_idata", bus.i_data, 32'h0);
    check("mr_drdata", bus.d_rdata, 32'h0);

    // Random traffic
    i_act = 0; d_act = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(99) == 0);
      if (!i_act && $urandom_range(1) == 1) begin
        i_act = 1;
        ia = {22'd0, 8'($urandom), 2'b00};
      end
      if (!d_act && $urandom_range(1) == 1) begin
        d_act = 1;
        dw = 1'($urandom);
        da = {22'd0, 8'($urandom), 2'b00};
        dwd = $urandom;
      end
      drive(r,
            i_act, i_act ? ia : $urandom,
            d_act, d_act ? dw : 1'($urandom),
            d_act ? da : $urandom,
            d_act ? dwd : $urandom);
      if (r || m_ai) i_act = 0;
      if (r || m_ad) d_act = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
